// File: rtl/tone_scheduler.sv
// Round-robin scheduler that lends a single buzzer tone generator to N_REQ requesters.
// Each grant plays one note for (L+1) ticks, then holds a silent gap before re-arbitrating.
module tone_scheduler #(
    parameter int N_REQ       = 4,
    parameter int TICK_CYCLES = 100000,
    parameter int GAP_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   note,
    input  logic [3*N_REQ-1:0]   octave,
    input  logic [8*N_REQ-1:0]   length,
    output logic [N_REQ-1:0]     gnt,
    output logic                 done,
    output logic                 abort,
    output logic                 busy,
    output logic                 tone_en,
    output logic [2:0]           tone_note,
    output logic [2:0]           tone_octave
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [TW-1:0]     tick_cnt, tick_next;
    logic [7:0]        remaining, remaining_next;
    logic [GW-1:0]     gap_cnt, gap_next;
    logic [IW-1:0]     last_grant, last_next;
    logic [N_REQ-1:0]  gnt_next;
    logic              done_next, abort_next, busy_next, tone_en_next;
    logic [2:0]        tone_note_next, tone_octave_next;

    logic [2:0]        note_arr   [N_REQ];
    logic [2:0]        octave_arr [N_REQ];
    logic [7:0]        length_arr [N_REQ];

    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand;
    logic              note_end;
    logic              finish;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign note_arr[i]   = note[3*i +: 3];
        assign octave_arr[i] = octave[3*i +: 3];
        assign length_arr[i] = length[8*i +: 8];
    end

    // Search upward from the requester after the last winner, wrapping to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_grant) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next       = state;
        gnt_next         = gnt;
        done_next        = 1'b0;
        abort_next       = 1'b0;
        tone_en_next     = tone_en;
        tone_note_next   = tone_note;
        tone_octave_next = tone_octave;
        tick_next        = tick_cnt;
        remaining_next   = remaining;
        gap_next         = gap_cnt;
        last_next        = last_grant;
        note_end         = 1'b0;
        finish           = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next       = PLAY;
                    gnt_next         = N_REQ'(1) << win_idx;
                    tone_en_next     = (note_arr[win_idx] != 3'd0);
                    tone_note_next   = note_arr[win_idx];
                    tone_octave_next = octave_arr[win_idx];
                    remaining_next   = length_arr[win_idx];
                    tick_next        = '0;
                    last_next        = win_idx;
                end
            end
            PLAY: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_next = '0;
                    if (remaining == 8'd0) begin
                        note_end = 1'b1;
                    end else begin
                        remaining_next = remaining - 8'd1;
                    end
                end else begin
                    tick_next = tick_cnt + TW'(1);
                end

                // A normal end takes priority over a simultaneous request drop.
                if (note_end) begin
                    done_next = 1'b1;
                    finish    = 1'b1;
                end else if ((req & gnt) == '0) begin
                    abort_next = 1'b1;
                    finish     = 1'b1;
                end

                if (finish) begin
                    gnt_next         = '0;
                    tone_en_next     = 1'b0;
                    tone_note_next   = 3'd0;
                    tone_octave_next = 3'd0;
                    gap_next         = '0;
                    state_next       = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_next       = IDLE;
                gnt_next         = '0;
                tone_en_next     = 1'b0;
                tone_note_next   = 3'd0;
                tone_octave_next = 3'd0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            done        <= 1'b0;
            abort       <= 1'b0;
            busy        <= 1'b0;
            tone_en     <= 1'b0;
            tone_note   <= 3'd0;
            tone_octave <= 3'd0;
            tick_cnt    <= '0;
            remaining   <= 8'd0;
            gap_cnt     <= '0;
            last_grant  <= LAST_INIT;
        end else begin
            state       <= state_next;
            gnt         <= gnt_next;
            done        <= done_next;
            abort       <= abort_next;
            busy        <= busy_next;
            tone_en     <= tone_en_next;
            tone_note   <= tone_note_next;
            tone_octave <= tone_octave_next;
            tick_cnt    <= tick_next;
            remaining   <= remaining_next;
            gap_cnt     <= gap_next;
            last_grant  <= last_next;
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler: directed vector table, reset corner case,
// and randomized transactions checked against a note-level timeline model.
module tb_tone_scheduler;

    localparam int N_REQ = 4;
    localparam int TICK  = 10;
    localparam int GAP   = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] note;
    logic [11:0] octave;
    logic [31:0] length;
    logic [3:0]  gnt;
    logic        done, abort, busy, tone_en;
    logic [2:0]  tone_note, tone_octave;

    int checks;
    int errors;
    int tb_last;

    tone_scheduler #(
        .N_REQ(N_REQ),
        .TICK_CYCLES(TICK),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .note(note),
        .octave(octave),
        .length(length),
        .gnt(gnt),
        .done(done),
        .abort(abort),
        .busy(busy),
        .tone_en(tone_en),
        .tone_note(tone_note),
        .tone_octave(tone_octave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rq;
        logic [2:0] nc;
        logic [2:0] oc;
        logic [7:0] len;
        int         exp_w;
        int         drop;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {18'd0, gnt, done, abort, busy, tone_en, tone_note, tone_octave};
    endfunction

    function automatic logic [31:0] expv(input logic [3:0] g, input logic d, input logic a,
                                         input logic b, input logic e, input logic [2:0] n,
                                         input logic [2:0] o);
        return {18'd0, g, d, a, b, e, n, o};
    endfunction

    function automatic int rr_winner(input logic [3:0] rq, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (rq[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    // One complete note: grant, play (possibly aborted at drop_at), gap, back to idle.
    task automatic run_txn(input logic [3:0] rq, input logic [11:0] nt, input logic [11:0] oc,
                           input logic [31:0] ln, input int w, input int drop_at, input string tag);
        logic [11:0] tn, to;
        logic [31:0] tl;
        logic [2:0]  en_note, en_oct;
        logic [3:0]  g;
        int          p, e;
        logic        exp_done;
        tn = nt >> (3 * w);
        to = oc >> (3 * w);
        tl = ln >> (8 * w);
        en_note = tn[2:0];
        en_oct  = to[2:0];
        p = (int'(tl[7:0]) + 1) * TICK;
        e = (drop_at > 0 && drop_at < p) ? drop_at : p;
        exp_done = (e == p);
        g = 4'b0001 << w;

        req = rq; note = nt; octave = oc; length = ln;
        tick();
        for (int c = 1; c <= e; c++) begin
            check($sformatf("%s play c%0d", tag, c), outs(),
                  expv(g, 1'b0, 1'b0, 1'b1, en_note != 3'd0, en_note, en_oct));
            req = 4'($urandom);
            req[w] = (drop_at > 0 && c >= drop_at) ? 1'b0 : 1'b1;
            note = 12'($urandom); octave = 12'($urandom); length = $urandom;
            tick();
        end
        check($sformatf("%s end", tag), outs(),
              expv(4'd0, exp_done, !exp_done, 1'b1, 1'b0, 3'd0, 3'd0));
        for (int gc = 2; gc <= GAP; gc++) begin
            req = 4'($urandom);
            tick();
            check($sformatf("%s gap%0d", tag, gc), outs(), expv(4'd0, 0, 0, 1'b1, 0, 3'd0, 3'd0));
        end
        req = 4'($urandom);
        tick();
        check($sformatf("%s idle", tag), outs(), expv(4'd0, 0, 0, 1'b0, 0, 3'd0, 3'd0));
        tb_last = w;
    endtask

    vec_t vecs[$];

    initial begin
        checks = 0; errors = 0; tb_last = N_REQ - 1;
        rst = 1'b1; req = 4'd0; note = 12'd0; octave = 12'd0; length = 32'd0;

        vecs.push_back('{4'b0001, 3'd5, 3'd4, 8'd2, 0, 0});
        vecs.push_back('{4'b1111, 3'd1, 3'd1, 8'd0, 1, 0});
        vecs.push_back('{4'b1111, 3'd2, 3'd2, 8'd0, 2, 0});
        vecs.push_back('{4'b1111, 3'd3, 3'd3, 8'd0, 3, 0});
        vecs.push_back('{4'b1111, 3'd4, 3'd5, 8'd0, 0, 0});
        vecs.push_back('{4'b1111, 3'd6, 3'd6, 8'd0, 1, 0});
        vecs.push_back('{4'b0011, 3'd0, 3'd3, 8'd1, 0, 0});
        vecs.push_back('{4'b0001, 3'd7, 3'd2, 8'd5, 0, 17});
        vecs.push_back('{4'b0001, 3'd3, 3'd1, 8'd1, 0, 20});
        vecs.push_back('{4'b1000, 3'd2, 3'd7, 8'd0, 3, 0});
        vecs.push_back('{4'b0110, 3'd5, 3'd0, 8'd1, 1, 0});
        vecs.push_back('{4'b0101, 3'd1, 3'd4, 8'd0, 2, 0});
        vecs.push_back('{4'b1100, 3'd6, 3'd2, 8'd0, 3, 0});
        vecs.push_back('{4'b0010, 3'd4, 3'd3, 8'd2, 1, 1});
        vecs.push_back('{4'b0011, 3'd7, 3'd7, 8'd0, 0, 0});

        tick(); tick();
        check("reset", outs(), expv(4'd0, 0, 0, 0, 0, 3'd0, 3'd0));
        rst = 1'b0;
        tick();
        check("idle no req", outs(), expv(4'd0, 0, 0, 0, 0, 3'd0, 3'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i].rq, {4{vecs[i].nc}}, {4{vecs[i].oc}}, {4{vecs[i].len}},
                    vecs[i].exp_w, vecs[i].drop, $sformatf("vec%0d", i));
        end

        // Reset during play: everything clears, then requester 0 wins first again.
        req = 4'b0001; note = {4{3'd5}}; octave = {4{3'd4}}; length = {4{8'd2}};
        tick();
        check("rst pre grant", outs(), expv(4'b0001, 0, 0, 1'b1, 1'b1, 3'd5, 3'd4));
        for (int c = 1; c < 12; c++) tick();
        rst = 1'b1;
        tick();
        check("rst mid note", outs(), expv(4'd0, 0, 0, 0, 0, 3'd0, 3'd0));
        rst = 1'b0;
        tb_last = N_REQ - 1;
        run_txn(4'b0011, {3'd1, 3'd2, 3'd3, 3'd6}, {3'd1, 3'd1, 3'd2, 3'd5}, 32'h00000001,
                0, 0, "post rst");

        for (int r = 0; r < 25; r++) begin
            logic [3:0]  rq;
            logic [11:0] nt, oc;
            logic [31:0] ln;
            int          w, l, drop, idle_n;
            idle_n = $urandom_range(0, 2);
            for (int k = 0; k < idle_n; k++) begin
                req = 4'd0;
                tick();
                check($sformatf("rnd%0d idle", r), outs(), expv(4'd0, 0, 0, 0, 0, 3'd0, 3'd0));
            end
            rq = 4'($urandom_range(1, 15));
            nt = 12'($urandom);
            oc = 12'($urandom);
            ln = 32'd0;
            for (int k = 0; k < N_REQ; k++) ln[8*k +: 8] = 8'($urandom_range(0, 2));
            w = rr_winner(rq, tb_last);
            l = int'(ln[8*w +: 8]);
            drop = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (l + 1) * TICK + 5) : 0;
            run_txn(rq, nt, oc, ln, w, drop, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_scheduler.md
TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing the buzzer tone generator.
REQ-002 The block SHALL have parameter TICK_CYCLES, default 100000, meaning the clk cycles per duration tick (1 ms at 100 MHz).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 1000, meaning the silent clk cycles inserted after every note.
REQ-004 The block SHALL have: clk  input  1  system clock; the only clock.
REQ-005 The block SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have: req  input  N_REQ  per-requester note request, level.
REQ-007 The block SHALL have: note  input  3*N_REQ  per-requester note code, slice i = bits 3i+2:3i; 0 = rest.
REQ-008 The block SHALL have: octave  input  3*N_REQ  per-requester octave code, same slicing.
REQ-009 The block SHALL have: length  input  8*N_REQ  per-requester duration L; the note lasts L+1 ticks.
REQ-010 The block SHALL have: gnt  output  N_REQ  one-hot grant; all zero when no note is owned.
REQ-011 The block SHALL have: done  output  1  one-cycle pulse when a granted note finishes normally.
REQ-012 The block SHALL have: abort  output  1  one-cycle pulse when a granted note is cut short.
REQ-013 The block SHALL have: busy  output  1  high in any state other than IDLE.
REQ-014 The block SHALL have: tone_en, tone_note[2:0], tone_octave[2:0]  outputs  tone generator drive.

Function
REQ-015 The FSM SHALL have states IDLE, PLAY and GAP; all outputs SHALL be registered.
REQ-016 IDLE: if any req bit is high at an edge, the block SHALL pick the winner round-robin, searching upward from last_grant+1 with wrap to 0.
REQ-017 At that same edge the block SHALL set gnt one-hot to the winner, latch note, octave and L, update last_grant, clear the tick counter, and enter PLAY; request-to-grant latency is one cycle.
REQ-018 In PLAY, tone_en SHALL be 1 when the latched note is nonzero and 0 for a rest; tone_note and tone_octave SHALL show the latched values; timing SHALL be identical for rests.
REQ-019 The tick counter SHALL count 0..TICK_CYCLES-1 and wrap; at each wrap the remaining count SHALL decrement; at the wrap where remaining = 0 the note SHALL end.
REQ-020 PLAY SHALL therefore last exactly (L+1)*TICK_CYCLES cycles; L=0 gives one tick, L=255 gives 256 ticks.
REQ-021 At note end the block SHALL, in one registered update, pulse done for one cycle, clear gnt and tone_en, and enter GAP.
REQ-022 Abort: if req of the granted requester is low at any PLAY edge, the block SHALL pulse abort for one cycle, clear gnt and tone_en, and enter GAP; done SHALL NOT pulse.
REQ-023 If the abort condition and the normal end occur on the same edge, normal end SHALL win (done=1, abort=0).
REQ-024 Inputs SHALL be latched at grant only; changes to note, octave or length during PLAY SHALL be ignored.
REQ-025 GAP SHALL hold all outputs silent for GAP_CYCLES cycles and then enter IDLE; with GAP_CYCLES=0 the block SHALL go PLAY -> IDLE directly.
REQ-026 Requests SHALL be ignored in PLAY and GAP and sampled only in IDLE, so a requester holding req continuously is re-arbitrated fairly after each note.
REQ-027 tone_note and tone_octave SHALL read 0 whenever the block is not in PLAY.

Reset
REQ-028 With rst high at an edge, the block SHALL go to IDLE and set gnt=0, done=0, abort=0, busy=0, tone_en=0, tone_note=0, tone_octave=0, counters=0, last_grant=N_REQ-1 (requester 0 wins first), regardless of state; this includes mid-note.
REQ-029 The first arbitration after reset release SHALL occur at the first edge where rst is low.

Verification (TICK_CYCLES=10, GAP_CYCLES=3, N_REQ=4)
REQ-030 req=0001, note0=5, oct0=4, L0=2 -> gnt=0001 one cycle later; tone_en=1, tone_note=5, tone_octave=4 for exactly 30 cycles; done pulse; 3 silent cycles; busy=0.
REQ-031 req=1111 held, all L=0 -> grant order 0,1,2,3,0 with a note of 10 cycles plus a 3-cycle gap each.
REQ-032 req0 granted with L=5, req0 dropped at cycle 17 of PLAY -> abort pulse next edge, no done, tone_en=0, then GAP.
REQ-033 note0=0 (rest), L0=1 -> gnt high for 20 cycles with tone_en=0 throughout, then a done pulse.
REQ-034 rst asserted at cycle 12 of a 30-cycle note -> next cycle all outputs 0 and state IDLE; with req=0011 after release, gnt=0001.
REQ-035 req0 dropped on the same edge as the final tick wrap -> done=1, abort=0.
